// File: rtl/de_pkg.sv
// Shared definitions for the forward-difference polynomial engine:
// FSM state encoding and coefficient-index sizing.
package de_pkg;

  localparam int MAX_ORDER = 7;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/de_lane.sv
// One difference lane: unsigned WIDTH-bit add that also reports the carry-out,
// which the top level folds into the per-run overflow flag.
module de_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/poly_diff_engine.sv
// Evaluates a polynomial of order ORDER at integer points by repeated forward
// differencing, starting from the initial differences D[0..ORDER] held in registers.
module poly_diff_engine
  import de_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 3,
  parameter int NW    = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NW-1:0]    n,
  input  logic             stream,
  input  logic             coef_we,
  input  logic [IDX_W-1:0] coef_idx,
  input  logic [WIDTH-1:0] coef_data,
  output logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             done_tick,
  output logic             overflow
);

  state_e state_q, state_d;

  logic [NW-1:0]    n_q, n_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    cnt_inc;
  logic             stream_q, stream_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] d_q [ORDER+1];
  logic [WIDTH-1:0] d_d [ORDER+1];
  logic [WIDTH-1:0] w_q [ORDER+1];
  logic [WIDTH-1:0] w_d [ORDER+1];

  logic [WIDTH-1:0] lane_sum [ORDER];
  logic [ORDER-1:0] lane_carry;

  assign cnt_inc = cnt_q + 1'b1;

  // Lane i adds the next-higher difference into W[i]; W[ORDER] never changes in a run.
  for (genvar i = 0; i < ORDER; i++) begin : g_lane
    de_lane #(.WIDTH(WIDTH)) u_lane (
      .a     (w_q[i]),
      .b     (w_q[i+1]),
      .sum   (lane_sum[i]),
      .carry (lane_carry[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: state_d = (n_q == '0) ? DONE : STEP;
      STEP: if (cnt_inc == n_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == IDLE);
    done_tick = (state_q == DONE);
    out_valid = stream_q && ((state_q == STEP) || (state_q == DONE));
    data_out  = w_q[0];
    overflow  = ovf_q;
  end

  // The working copy is taken on the start-sampling edge, so coefficient writes
  // made at or after that edge only reach later runs.
  always_comb begin
    n_d      = n_q;
    stream_d = stream_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    d_d      = d_q;
    w_d      = w_q;

    for (int i = 0; i <= ORDER; i++) begin
      if (coef_we && (coef_idx == IDX_W'(i))) d_d[i] = coef_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n;
          stream_d = stream;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          for (int i = 0; i <= ORDER; i++) w_d[i] = d_q[i];
        end
      end
      STEP: begin
        for (int i = 0; i < ORDER; i++) w_d[i] = lane_sum[i];
        cnt_d = cnt_inc;
        if (|lane_carry) ovf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q      <= '0;
      stream_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      d_q      <= '{default: '0};
      w_q      <= '{default: '0};
    end else begin
      n_q      <= n_d;
      stream_q <= stream_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      d_q      <= d_d;
      w_q      <= w_d;
    end
  end

endmodule

// File: tb/tb_poly_diff_engine.sv
// Scoreboard bench: a 32-bit order-3 engine and an 8-bit order-2 engine share all
// inputs; expected values come from a binomial-sum model of the written coefficients.
module tb_poly_diff_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  n;
  logic        stream;
  logic        coef_we;
  logic [2:0]  coef_idx;
  logic [31:0] coef_data;

  logic        ready32, valid32, done32, ovf32;
  logic [31:0] data32;
  logic        ready8, valid8, done8, ovf8;
  logic [7:0]  data8;

  typedef struct {
    bit          chk;
    logic [63:0] val;
    bit          ovf;
  } done_t;

  done_t       d32_q[$];
  done_t       d8_q[$];
  logic [63:0] s32_q[$];
  logic [63:0] s8_q[$];
  logic [31:0] d_model [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  poly_diff_engine #(.WIDTH(32), .ORDER(3), .NW(6)) dut32 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .n         (n),
    .stream    (stream),
    .coef_we   (coef_we),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .ready     (ready32),
    .data_out  (data32),
    .out_valid (valid32),
    .done_tick (done32),
    .overflow  (ovf32)
  );

  poly_diff_engine #(.WIDTH(8), .ORDER(2), .NW(6)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .n         (n),
    .stream    (stream),
    .coef_we   (coef_we),
    .coef_idx  (coef_idx),
    .coef_data (coef_data[7:0]),
    .ready     (ready8),
    .data_out  (data8),
    .out_valid (valid8),
    .done_tick (done8),
    .overflow  (ovf8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // f(k) = sum_i D[i] * C(k,i), independent of the difference recurrence.
  function automatic longint polyModel(input int k, input int ord);
    longint acc = 0;
    longint c   = 1;
    for (int i = 0; i <= ord; i++) begin
      acc += longint'(d_model[i]) * c;
      c = c * (k - i) / (i + 1);
    end
    return acc;
  endfunction

  task automatic writeCoef(input int idx, input logic [31:0] val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_idx  = 3'(idx);
    coef_data = val;
    if (idx <= 3) d_model[idx] = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic applyStimulus(input int nv, input bit strm, input bit chk8, input bit ovf8_exp,
                               input int busy_at, input int cw_at, input int cw_idx,
                               input logic [31:0] cw_val);
    done_t e;
    int    lat;
    e.chk = 1'b1; e.val = polyModel(nv, 3) & 64'hFFFF_FFFF; e.ovf = 1'b0;
    d32_q.push_back(e);
    e.chk = chk8; e.val = polyModel(nv, 2) & 64'hFF; e.ovf = ovf8_exp;
    d8_q.push_back(e);
    if (strm) begin
      for (int k = 0; k <= nv; k++) begin
        s32_q.push_back(polyModel(k, 3) & 64'hFFFF_FFFF);
        s8_q.push_back(polyModel(k, 2) & 64'hFF);
      end
    end
    @(negedge clk);
    start  = 1'b1;
    n      = 6'(nv);
    stream = strm;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    checkOutput("ready_busy", 64'(ready32), 64'd0);
    while (!done32 && lat < 200) begin
      start   = (lat == busy_at);
      if (lat == busy_at) n = 6'd2;
      coef_we = (lat == cw_at);
      if (lat == cw_at) begin
        coef_idx  = 3'(cw_idx);
        coef_data = cw_val;
        d_model[cw_idx] = cw_val;
      end
      @(negedge clk);
      lat++;
    end
    start   = 1'b0;
    coef_we = 1'b0;
    checkOutput("latency", 64'(lat), 64'(nv + 1));
    @(negedge clk);
    checkOutput("ready_after", 64'(ready32), 64'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (valid32) begin
        if (s32_q.size() == 0) checkOutput("valid32_unexpected", 64'(valid32), 64'd0);
        else checkOutput("stream32", 64'(data32), s32_q.pop_front());
      end
      if (valid8) begin
        if (s8_q.size() == 0) checkOutput("valid8_unexpected", 64'(valid8), 64'd0);
        else checkOutput("stream8", 64'(data8), s8_q.pop_front());
      end
      if (done32) begin
        if (d32_q.size() == 0) checkOutput("done32_unexpected", 64'(done32), 64'd0);
        else begin
          done_t e;
          e = d32_q.pop_front();
          checkOutput("result32", 64'(data32), e.val);
          checkOutput("ovf32", 64'(ovf32), 64'(e.ovf));
        end
      end
      if (done8) begin
        if (d8_q.size() == 0) checkOutput("done8_unexpected", 64'(done8), 64'd0);
        else begin
          done_t e;
          e = d8_q.pop_front();
          if (e.chk) begin
            checkOutput("result8", 64'(data8), e.val);
            checkOutput("ovf8", 64'(ovf8), 64'(e.ovf));
          end
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    n         = '0;
    stream    = 1'b0;
    coef_we   = 1'b0;
    coef_idx  = '0;
    coef_data = '0;
    d_model   = '{default: '0};
    repeat (3) @(negedge clk);
    checkOutput("rst_ready32", 64'(ready32), 64'd1);
    checkOutput("rst_data32", 64'(data32), 64'd0);
    checkOutput("rst_valid32", 64'(valid32), 64'd0);
    checkOutput("rst_done32", 64'(done32), 64'd0);
    checkOutput("rst_ovf32", 64'(ovf32), 64'd0);
    checkOutput("rst_ready8", 64'(ready8), 64'd1);
    reset_n = 1'b1;

    $display("[TB] square, stream and zero runs");
    writeCoef(0, 0); writeCoef(1, 1); writeCoef(2, 2); writeCoef(3, 0);
    writeCoef(5, 32'd99);
    applyStimulus(5, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0);
    applyStimulus(4, 1'b1, 1'b1, 1'b0, -1, -1, 0, 0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0);

    $display("[TB] cube run");
    writeCoef(0, 0); writeCoef(1, 1); writeCoef(2, 6); writeCoef(3, 6);
    applyStimulus(10, 1'b0, 1'b0, 1'b0, -1, -1, 0, 0);

    $display("[TB] overflow runs");
    writeCoef(2, 2); writeCoef(3, 0);
    applyStimulus(16, 1'b0, 1'b1, 1'b1, -1, -1, 0, 0);
    applyStimulus(3, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0);

    $display("[TB] busy start and mid-run coefficient write");
    applyStimulus(20, 1'b0, 1'b1, 1'b1, 5, -1, 0, 0);
    repeat (4) @(negedge clk);
    applyStimulus(6, 1'b0, 1'b1, 1'b0, -1, 3, 2, 32'd4);
    applyStimulus(3, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0);

    $display("[TB] abort by reset");
    @(negedge clk);
    start = 1'b1;
    n     = 6'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    d_model = '{default: '0};
    #1;
    checkOutput("abort_ready32", 64'(ready32), 64'd1);
    checkOutput("abort_data32", 64'(data32), 64'd0);
    checkOutput("abort_done32", 64'(done32), 64'd0);
    checkOutput("abort_data8", 64'(data8), 64'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", 64'(done32), 64'd0);
    end
    reset_n = 1'b1;
    applyStimulus(5, 1'b0, 1'b1, 1'b0, -1, -1, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("done32_left", 64'(d32_q.size()), 64'd0);
    checkOutput("stream32_left", 64'(s32_q.size()), 64'd0);
    checkOutput("done8_left", 64'(d8_q.size()), 64'd0);
    checkOutput("stream8_left", 64'(s8_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_diff_engine.md
POLY_DIFF_ENGINE -- requirements
Module: poly_diff_engine

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the data and difference-register width in bits.
REQ-002 The module SHALL have parameter ORDER, default 3, the polynomial order (legal range 1..7).
REQ-003 The module SHALL have parameter NW, default 6, the width of the step-count input n.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port start  input  1  a run request, sampled only while ready=1.
REQ-007 The module SHALL have port n  input  NW  the target index, evaluating f(n) by n difference steps.
REQ-008 The module SHALL have port stream  input  1  a mode select sampled with start: 1 emits every f(k), k=0..n.
REQ-009 The module SHALL have port coef_we  input  1  a write strobe for the initial-difference registers.
REQ-010 The module SHALL have port coef_idx  input  3  the index i of D[i] (D[0]=f(0), D[i]=i-th forward difference at 0).
REQ-011 The module SHALL have port coef_data  input  WIDTH  the value written into D[coef_idx].
REQ-012 The module SHALL have port ready  output  1  which is high exactly when the FSM is in IDLE.
REQ-013 The module SHALL have port data_out  output  WIDTH  which carries the working register W[0], the current f(k).
REQ-014 The module SHALL have port out_valid  output  1  which is the per-value strobe in stream mode.
REQ-015 The module SHALL have port done_tick  output  1  which is a one-cycle pulse when f(n) is on data_out.
REQ-016 The module SHALL have port overflow  output  1  which is a sticky-per-run flag for any unsigned carry-out.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, STEP and DONE, with IDLE->INIT on start=1, INIT->DONE if n=0 else INIT->STEP, STEP->DONE on the step where cnt reaches n, and DONE->IDLE unconditionally.
REQ-018 In IDLE with start=1, the module SHALL latch n and stream.
REQ-019 On the INIT edge, the module SHALL copy W[i]<=D[i] for i=0..ORDER, clear cnt and clear overflow.
REQ-020 On each STEP edge, the module SHALL update W[i]<=W[i]+W[i+1] for all i<ORDER simultaneously using pre-edge values, hold W[ORDER], and increment cnt.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, and a carry-out in any lane on any step SHALL set overflow, which holds until the next INIT.
REQ-022 done_tick SHALL be high for exactly the one cycle in DONE, occurring n+1 cycles after the edge that sampled start.
REQ-023 data_out SHALL hold f(n) from DONE until the next INIT edge.
REQ-024 With stream=1 latched, out_valid SHALL be high in every STEP and DONE cycle (n+1 values, f(0)..f(n) in order); with stream=0, out_valid SHALL be 0.
REQ-025 A start asserted while ready=0 SHALL be ignored without being queued.
REQ-026 coef_we SHALL be accepted in any state, and a write during a run SHALL affect only later runs.
REQ-027 coef_we with coef_idx>ORDER SHALL be ignored.
REQ-028 ready SHALL fall on the INIT edge and rise on the DONE->IDLE edge, so back-to-back runs are possible with one idle cycle.

Reset
REQ-029 While reset_n=0, the FSM SHALL be in IDLE and all D[i], W[i], cnt and latched n/stream SHALL be 0.
REQ-030 While reset_n=0, the outputs SHALL be data_out=0, out_valid=0, done_tick=0, overflow=0 and ready=1.
REQ-031 Reset asserted mid-run SHALL abort the run immediately, with no done_tick and with the coefficients lost.
REQ-032 Release of reset_n SHALL take effect at the next clk edge, and start SHALL be sampled no earlier than that edge.

Structure
REQ-033 Shared package de_pkg SHALL hold the state enumeration (IDLE/INIT/STEP/DONE), MAX_ORDER=7 and the coefficient index width 3.
REQ-034 One sub-module, de_lane (a WIDTH-bit adder returning sum and carry), SHALL be instantiated ORDER times via generate.
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Square test: with WIDTH=32, ORDER=2, D={0,1,2} and n=5 -> data_out=25, done_tick 6 cycles after the start edge, overflow=0.
REQ-037 Cube test: with ORDER=3, D={0,1,6,6} and n=10 -> data_out=1000.
REQ-038 Stream and zero tests: with D={0,1,2}, n=4 and stream=1 -> out_valid values 0,1,4,9,16, with done_tick on 16; with n=0 -> done_tick 1 cycle after the start edge and data_out=0.
REQ-039 Overflow test: with WIDTH=8, D={0,1,2} and n=16 -> data_out=0 and overflow=1; a following run with n=3 -> overflow=0 and data_out=9.
REQ-040 Abort and ignore tests: with n=20, reset_n=0 at step 7 -> outputs at reset values with no done_tick; start reasserted during a busy run -> ignored and exactly one done_tick; coef write during a run -> current result unchanged and next run uses the new D.
